// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback
// sequencing, ALU decode, immediate select and all datapath enables.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unsupported opcodes trap
// and raise a sticky illegal_op flag instead of silently refetching).
module multicycle_controller #(
  parameter int RESET_STATE_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               op,
  input  logic [2:0]               funct3,
  input  logic                     funct7b5,
  input  logic                     zero,
  output logic                     pc_write,
  output logic                     adr_src,
  output logic                     mem_write,
  output logic                     ir_write,
  output logic [1:0]               result_src,
  output logic [1:0]               alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               imm_src,
  output logic [2:0]               alu_control,
  output logic                     reg_write,
  output logic                     illegal_op,
  output logic [RESET_STATE_W-1:0] state_o
);

  localparam logic [RESET_STATE_W-1:0] S_FETCH    = RESET_STATE_W'(0);
  localparam logic [RESET_STATE_W-1:0] S_DECODE   = RESET_STATE_W'(1);
  localparam logic [RESET_STATE_W-1:0] S_MEMADR   = RESET_STATE_W'(2);
  localparam logic [RESET_STATE_W-1:0] S_MEMREAD  = RESET_STATE_W'(3);
  localparam logic [RESET_STATE_W-1:0] S_MEMWB    = RESET_STATE_W'(4);
  localparam logic [RESET_STATE_W-1:0] S_MEMWRITE = RESET_STATE_W'(5);
  localparam logic [RESET_STATE_W-1:0] S_EXECR    = RESET_STATE_W'(6);
  localparam logic [RESET_STATE_W-1:0] S_EXECI    = RESET_STATE_W'(7);
  localparam logic [RESET_STATE_W-1:0] S_ALUWB    = RESET_STATE_W'(8);
  localparam logic [RESET_STATE_W-1:0] S_BEQ      = RESET_STATE_W'(9);
  localparam logic [RESET_STATE_W-1:0] S_JAL      = RESET_STATE_W'(10);
  localparam logic [RESET_STATE_W-1:0] S_TRAP     = RESET_STATE_W'(11);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [RESET_STATE_W-1:0] state_r;
  logic [RESET_STATE_W-1:0] next_state_s;
  logic [2:0]               alu_dec_s;
  logic                     pc_update_s;
  logic                     branch_s;
  logic                     ir_write_s;
  logic                     mem_write_s;
  logic                     reg_write_s;

  // State register; reset overrides any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_state_s = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_R:         next_state_s = S_EXECR;
          OP_I:         next_state_s = S_EXECI;
          OP_BEQ:       next_state_s = S_BEQ;
          OP_JAL:       next_state_s = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      next_state_s = S_TRAP;
`else
          default:      next_state_s = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD:  next_state_s = S_MEMWB;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: next_state_s = S_FETCH;
      S_EXECR:    next_state_s = S_ALUWB;
      S_EXECI:    next_state_s = S_ALUWB;
      S_ALUWB:    next_state_s = S_FETCH;
      S_BEQ:      next_state_s = S_FETCH;
      S_JAL:      next_state_s = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     next_state_s = S_TRAP;
`else
      S_TRAP:     next_state_s = S_FETCH;
`endif
      default:    next_state_s = S_FETCH;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky flag set on the decode-to-trap transition, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_r <= 1'b0;
    end else if ((state_r == S_DECODE) && (next_state_s == S_TRAP)) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal_op = illegal_r;
`else
  assign illegal_op = 1'b0;
`endif

  // ALU operation from funct fields; sub only for R-type with funct7b5.
  always_comb begin
    alu_dec_s = 3'b000;
    case (funct3)
      3'b000: begin
        if (op[5] && funct7b5) begin
          alu_dec_s = 3'b001;
        end else begin
          alu_dec_s = 3'b000;
        end
      end
      3'b010:  alu_dec_s = 3'b101;
      3'b110:  alu_dec_s = 3'b011;
      3'b111:  alu_dec_s = 3'b010;
      default: alu_dec_s = 3'b000;
    endcase
  end

  // Moore output decode from the registered state; unlisted outputs stay 0.
  always_comb begin
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    adr_src     = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    alu_control = 3'b000;
    case (state_r)
      S_FETCH: begin
        ir_write_s  = 1'b1;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        pc_update_s = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (op == OP_LW) begin
          imm_src = 2'b00;
        end else begin
          imm_src = 2'b01;
        end
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec_s;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec_s;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        branch_s    = 1'b1;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        pc_update_s = 1'b1;
        imm_src     = 2'b11;
      end
      default: begin
        pc_update_s = 1'b0;
      end
    endcase
  end

  // Architectural enables are suppressed while reset is asserted.
  assign pc_write  = (pc_update_s | (branch_s & zero)) & ~reset;
  assign ir_write  = ir_write_s  & ~reset;
  assign mem_write = mem_write_s & ~reset;
  assign reg_write = reg_write_s & ~reset;
  assign state_o   = state_r;

endmodule
